addsub_arbiter: RTL

Two-port arbiter and sequencer in front of the shared N-bit ripple-carry adder/subtractor datapath (`Adder_subtractor` with per-bit `FullAdder` cells). Requesters 0 and 1 submit operand pairs with a valid/ready handshake. The block grants the datapath round-robin, registers operands for one execute cycle, and returns each result through a per-requester response slot that holds its data until acknowledged. The block instantiates exactly one `Adder_subtractor #(N)` internally.

---
 rtl/addsub_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-port round-robin front end for a shared N-bit ripple
// adder/subtractor. Each requester gets one registered response slot that
// holds its result until acknowledged.
// Optional feature macro: ADDSUB_ARB_OVERFLOW_EN adds the rsp_ovf port and
// the per-slot signed-overflow register.

// One-bit full adder cell used by the ripple chain.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// N-bit ripple-carry adder/subtractor: R = X + (Y ^ {N{sub}}) + sub.
module Adder_subtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         sub,
  output logic [N-1:0] R,
  output logic         cout
);
  logic [N:0]   carry_s;
  logic [N-1:0] yc_s;

  assign yc_s       = Y ^ {N{sub}};
  assign carry_s[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_bit
    FullAdder u_fa (
      .a    (X[i]),
      .b    (yc_s[i]),
      .cin  (carry_s[i]),
      .s    (R[i]),
      .cout (carry_s[i+1])
    );
  end

  assign cout = carry_s[N];
endmodule

module addsub_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_x,
  input  logic [2*N-1:0] req_y,
  input  logic [1:0]     req_sub,
  output logic [1:0]     rsp_valid,
  output logic [2*N-1:0] rsp_result,
  output logic [1:0]     rsp_carry,
`ifdef ADDSUB_ARB_OVERFLOW_EN
  output logic [1:0]     rsp_ovf,
`endif
  input  logic [1:0]     rsp_ack
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           grant_q, grant_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic           sub_q, sub_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]     rsp_carry_q, rsp_carry_d;
`ifdef ADDSUB_ARB_OVERFLOW_EN
  logic [1:0]     rsp_ovf_q, rsp_ovf_d;
`endif

  logic [1:0]     elig_s;
  logic [1:0]     ready_s;
  logic [1:0]     fire_s;
  logic [N-1:0]   sum_s;
  logic           cout_s;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_fn(input logic x_msb, input logic yc_msb,
                                  input logic r_msb);
    return (~(x_msb ^ yc_msb)) & (r_msb ^ x_msb);
  endfunction

  // Shared datapath, fed only from the operand registers.
  Adder_subtractor #(.N(N)) u_addsub (
    .X    (x_q),
    .Y    (y_q),
    .sub  (sub_q),
    .R    (sum_s),
    .cout (cout_s)
  );

  assign elig_s = req_valid & ~rsp_valid_q;

  // Arbitration: ready[k] looks only at the other requester's valid, so a
  // requester's own valid never feeds its ready combinationally.
  always_comb begin
    ready_s = 2'b00;
    case (state_q)
      ST_IDLE: begin
        ready_s[0] = ~rsp_valid_q[0] & (~elig_s[1] | (prio_q == 1'b0));
        ready_s[1] = ~rsp_valid_q[1] & (~elig_s[0] | (prio_q == 1'b1));
      end
      ST_EXEC: begin
        ready_s = 2'b00;
      end
      default: begin
        ready_s = 2'b00;
      end
    endcase
  end

  // At most one bit can fire: with both eligible only prio gets ready.
  assign fire_s = req_valid & ready_s;

  // Hold ready low while reset is asserted so nothing appears accepted.
  assign req_ready = ready_s & {2{~rst}};

  // Next-state: accept in IDLE, write the granted slot in EXEC, release on ack.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    x_d          = x_q;
    y_d          = y_q;
    sub_d        = sub_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
`ifdef ADDSUB_ARB_OVERFLOW_EN
    rsp_ovf_d    = rsp_ovf_q;
`endif
    // Ack of an empty slot is harmless: clearing a zero bit changes nothing.
    rsp_valid_d  = rsp_valid_q & ~rsp_ack;

    case (state_q)
      ST_IDLE: begin
        if (fire_s != 2'b00) begin
          grant_d = fire_s[1];
          prio_d  = ~fire_s[1];
          state_d = ST_EXEC;
          if (fire_s[1]) begin
            x_d   = req_x[N +: N];
            y_d   = req_y[N +: N];
            sub_d = req_sub[1];
          end else begin
            x_d   = req_x[0 +: N];
            y_d   = req_y[0 +: N];
            sub_d = req_sub[0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The granted slot was empty at accept, so no ack can race this set.
        rsp_valid_d[grant_q] = 1'b1;
        rsp_carry_d[grant_q] = cout_s;
`ifdef ADDSUB_ARB_OVERFLOW_EN
        rsp_ovf_d[grant_q]   = ovf_fn(x_q[N-1], y_q[N-1] ^ sub_q, sum_s[N-1]);
`endif
        if (grant_q) begin
          rsp_result_d[N +: N] = sum_s;
        end else begin
          rsp_result_d[0 +: N] = sum_s;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and slot registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      grant_q      <= 1'b0;
      x_q          <= {N{1'b0}};
      y_q          <= {N{1'b0}};
      sub_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= {(2*N){1'b0}};
      rsp_carry_q  <= 2'b00;
`ifdef ADDSUB_ARB_OVERFLOW_EN
      rsp_ovf_q    <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sub_q        <= sub_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
`ifdef ADDSUB_ARB_OVERFLOW_EN
      rsp_ovf_q    <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
`ifdef ADDSUB_ARB_OVERFLOW_EN
  assign rsp_ovf    = rsp_ovf_q;
`endif

endmodule
